pc_branch_stack: RTL and testbench

PC_BRANCH_STACK -- requirements
Module: pc_branch_stack

---
 rtl/pc_branch_stack_pkg.sv | 25 ++
 rtl/pc_ret_stack.sv | 52 +++++
 rtl/pc_branch_stack.sv | 109 ++++++++++
 tb/tb_pc_branch_stack.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pc_branch_stack_pkg.sv
// Shared definitions for the program-counter / branch unit.
//   - Instruction opcodes understood by pc_branch_stack.
//     B/BP/BN/BZ keep their established encodings.
//     CALL and RET sit on codes the instruction set did not use before.
//   - Enumerated classification of what an update cycle does to the PC.
package pc_branch_stack_pkg;

  localparam logic [3:0] B_OPCODE    = 4'h4;
  localparam logic [3:0] BP_OPCODE   = 4'h5;
  localparam logic [3:0] BN_OPCODE   = 4'h6;
  localparam logic [3:0] BZ_OPCODE   = 4'h7;
  localparam logic [3:0] CALL_OPCODE = 4'h9;
  localparam logic [3:0] RET_OPCODE  = 4'hA;

  // Action selected for one update cycle, before REPC gating.
  typedef enum logic [2:0] {
    XFER_HOLD,  // pc unchanged, no stack activity
    XFER_INC,   // sequential pc+1
    XFER_JUMP,  // relative branch taken
    XFER_CALL,  // push return address, jump to target
    XFER_RET,   // pop return address into pc
    XFER_ERR    // CALL on full / RET on empty stack
  } xfer_e;

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address LIFO for pc_branch_stack.
// Ports:
//   clk, reset_pc    clock, asynchronous active-high reset (empties the stack)
//   push, push_data  write push_data on top; ignored when full
//   pop              discard top entry; ignored when empty
//   top              current top entry (don't-care when empty)
//   full, empty      occupancy flags, combinational from the stack pointer
module pc_ret_stack #(
  parameter int PC_W        = 10,
  parameter int STACK_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_pc,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top,
  output logic            full,
  output logic            empty
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [SP_W-1:0] sp;
  logic [SP_W-1:0] sp_m1;
  logic [PC_W-1:0] mem [STACK_DEPTH];

  assign full  = (sp == SP_W'(STACK_DEPTH));
  assign empty = (sp == '0);
  assign sp_m1 = sp - SP_W'(1);
  assign top   = mem[sp_m1[IDX_W-1:0]];

  // Only the pointer is reset; entry contents are meaningless once sp drops.
  always_ff @(posedge clk or posedge reset_pc) begin
    if (reset_pc) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + SP_W'(1);
    end else if (pop && !empty) begin
      sp <= sp_m1;
    end
  end

  // sp < STACK_DEPTH whenever a push is accepted, so the truncated index is in range.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[sp[IDX_W-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/pc_branch_stack.sv
// Program counter with PC-relative branches and a CALL/RET return stack.
// Ports:
//   clk, reset_pc     clock, asynchronous active-high reset
//   REPC              update enable; nothing changes when low
//   INC               sequential increment, overrides ir_opcode
//   ir_opcode         instruction opcode (see pc_branch_stack_pkg)
//   R_val             register value tested by BP/BN/BZ
//   ir_operand_addr   signed PC-relative offset
//   pc                registered program counter
//   taken             one-cycle pulse after an executed transfer
//   stack_full/empty  return stack occupancy
//   stack_err         sticky overflow/underflow flag, cleared only by reset
module pc_branch_stack
  import pc_branch_stack_pkg::*;
#(
  parameter int PC_W        = 10,
  parameter int DATA_W      = 8,
  parameter int OFF_W       = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_pc,
  input  logic              REPC,
  input  logic              INC,
  input  logic [3:0]        ir_opcode,
  input  logic [DATA_W-1:0] R_val,
  input  logic [OFF_W-1:0]  ir_operand_addr,
  output logic [PC_W-1:0]   pc,
  output logic              taken,
  output logic              stack_full,
  output logic              stack_empty,
  output logic              stack_err
);

  function automatic logic signed [PC_W-1:0] sext_off(input logic signed [OFF_W-1:0] off);
    return PC_W'(off);
  endfunction

  xfer_e           xfer;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] ret_addr;
  logic            push;
  logic            pop;

  // Both sums wrap naturally modulo 2^PC_W.
  assign pc_inc = pc + PC_W'(1);
  assign target = pc + $unsigned(sext_off($signed(ir_operand_addr)));

  always_comb begin
    xfer = XFER_HOLD;
    if (INC) begin
      xfer = XFER_INC;
    end else begin
      case (ir_opcode)
        B_OPCODE:    xfer = XFER_JUMP;
        BP_OPCODE:   if (!R_val[DATA_W-1]) xfer = XFER_JUMP;
        BN_OPCODE:   if (R_val[DATA_W-1])  xfer = XFER_JUMP;
        BZ_OPCODE:   if (R_val == '0)      xfer = XFER_JUMP;
        CALL_OPCODE: xfer = stack_full  ? XFER_ERR : XFER_CALL;
        RET_OPCODE:  xfer = stack_empty ? XFER_ERR : XFER_RET;
        default:     xfer = XFER_HOLD;
      endcase
    end
  end

  assign push = REPC && (xfer == XFER_CALL);
  assign pop  = REPC && (xfer == XFER_RET);

  pc_ret_stack #(
    .PC_W        (PC_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk       (clk),
    .reset_pc  (reset_pc),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top       (ret_addr),
    .full      (stack_full),
    .empty     (stack_empty)
  );

  always_ff @(posedge clk or posedge reset_pc) begin
    if (reset_pc) begin
      pc        <= '0;
      taken     <= 1'b0;
      stack_err <= 1'b0;
    end else begin
      taken <= 1'b0;
      if (REPC) begin
        case (xfer)
          XFER_INC: pc <= pc_inc;
          XFER_JUMP, XFER_CALL: begin
            pc    <= target;
            taken <= 1'b1;
          end
          XFER_RET: begin
            pc    <= ret_addr;
            taken <= 1'b1;
          end
          XFER_ERR: stack_err <= 1'b1;
          default:  ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_branch_stack.sv
module tb_pc_branch_stack;
  import pc_branch_stack_pkg::*;

  localparam int PC_W        = 10;
  localparam int DATA_W      = 8;
  localparam int OFF_W       = 8;
  localparam int STACK_DEPTH = 4;
  localparam int PC_MOD      = 1 << PC_W;

  logic              clk = 1'b0;
  logic              reset_pc = 1'b1;
  logic              REPC = 1'b0;
  logic              INC = 1'b0;
  logic [3:0]        ir_opcode = 4'h0;
  logic [DATA_W-1:0] R_val = '0;
  logic [OFF_W-1:0]  ir_operand_addr = '0;
  logic [PC_W-1:0]   pc;
  logic              taken;
  logic              stack_full;
  logic              stack_empty;
  logic              stack_err;

  pc_branch_stack #(
    .PC_W(PC_W), .DATA_W(DATA_W), .OFF_W(OFF_W), .STACK_DEPTH(STACK_DEPTH)
  ) dut (
    .clk(clk), .reset_pc(reset_pc), .REPC(REPC), .INC(INC),
    .ir_opcode(ir_opcode), .R_val(R_val), .ir_operand_addr(ir_operand_addr),
    .pc(pc), .taken(taken), .stack_full(stack_full),
    .stack_empty(stack_empty), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  // Behavioural model: integer pc, queue as the LIFO.
  int m_pc    = 0;
  int m_stack[$];
  bit m_err   = 0;
  bit m_taken = 0;

  task automatic model_update();
    int tgt;
    if (reset_pc) begin
      m_pc = 0; m_stack.delete(); m_err = 0; m_taken = 0;
    end else begin
      m_taken = 0;
      if (REPC) begin
        tgt = m_pc + int'($signed(ir_operand_addr));
        tgt = ((tgt % PC_MOD) + PC_MOD) % PC_MOD;
        if (INC) m_pc = (m_pc + 1) % PC_MOD;
        else if (ir_opcode == B_OPCODE ||
                 (ir_opcode == BP_OPCODE && R_val[DATA_W-1] == 1'b0) ||
                 (ir_opcode == BN_OPCODE && R_val[DATA_W-1] == 1'b1) ||
                 (ir_opcode == BZ_OPCODE && R_val == 0)) begin
          m_pc = tgt; m_taken = 1;
        end else if (ir_opcode == CALL_OPCODE) begin
          if (m_stack.size() == STACK_DEPTH) m_err = 1;
          else begin
            m_stack.push_back((m_pc + 1) % PC_MOD); m_pc = tgt; m_taken = 1;
          end
        end else if (ir_opcode == RET_OPCODE) begin
          if (m_stack.size() == 0) m_err = 1;
          else begin
            m_pc = m_stack.pop_back(); m_taken = 1;
          end
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset_pc);
    model_update();
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("cyc_pc", int'(pc), m_pc);
      check("cyc_taken", int'(taken), int'(m_taken));
      check("cyc_full", int'(stack_full), int'(m_stack.size() == STACK_DEPTH));
      check("cyc_empty", int'(stack_empty), int'(m_stack.size() == 0));
      check("cyc_err", int'(stack_err), int'(m_err));
    end
  end

  task automatic step(input bit repc, input bit inc, input logic [3:0] op,
                      input logic [7:0] rv, input logic [7:0] off);
    @(negedge clk);
    REPC = repc; INC = inc; ir_opcode = op; R_val = rv; ir_operand_addr = off;
    @(posedge clk);
    #1;
  endtask

  // Pins both the DUT and the model to a hand-computed pc.
  task automatic lit_pc(input string name, input int exp);
    check({name, "_dut"}, int'(pc), exp);
    check({name, "_model"}, m_pc, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    REPC = 0; INC = 0;
    reset_pc = 1;
    #2;
    reset_pc = 0;
  endtask

  initial begin
    // Reset held across a clock edge.
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", int'(pc), 0);
    check("rst_taken", int'(taken), 0);
    check("rst_empty", int'(stack_empty), 1);
    check("rst_full", int'(stack_full), 0);
    check("rst_err", int'(stack_err), 0);
    @(negedge clk);
    reset_pc = 0;
    chk_en = 1;

    // Backward branch from 5 to 3, taken pulses once.
    for (int i = 0; i < 5; i++) step(1, 1, 4'h0, 8'h00, 8'h00);
    lit_pc("inc5", 5);
    step(1, 0, B_OPCODE, 8'h00, 8'hFE);
    lit_pc("b_back", 3);
    check("b_back_taken", int'(taken), 1);
    step(0, 0, 4'h0, 8'h00, 8'h00);
    check("taken_pulse", int'(taken), 0);

    // Wrap in both directions.
    do_reset();
    step(1, 0, B_OPCODE, 8'h00, 8'hFF);
    lit_pc("wrap_neg", 1023);
    step(1, 1, 4'h0, 8'h00, 8'h00);
    lit_pc("inc_wrap", 0);
    step(1, 0, B_OPCODE, 8'h00, 8'hFC);
    lit_pc("to_1020", 1020);
    step(1, 0, B_OPCODE, 8'h00, 8'h05);
    lit_pc("wrap_pos", 1);
    step(1, 1, 4'h0, 8'h00, 8'h00);
    step(1, 0, B_OPCODE, 8'h00, 8'hFC);
    lit_pc("wrap_2m4", 1022);

    // Conditional branches.
    step(1, 0, BP_OPCODE, 8'h00, 8'h02);
    lit_pc("bp_zero", 0);
    check("bp_taken", int'(taken), 1);
    step(1, 0, BN_OPCODE, 8'h80, 8'h03);
    lit_pc("bn_neg", 3);
    step(1, 0, BZ_OPCODE, 8'h01, 8'h05);
    lit_pc("bz_nz", 3);
    check("bz_nz_taken", int'(taken), 0);
    step(1, 0, BZ_OPCODE, 8'h00, 8'h05);
    lit_pc("bz_z", 8);
    step(1, 1, B_OPCODE, 8'h00, 8'h40);
    lit_pc("inc_prio", 9);
    check("inc_prio_taken", int'(taken), 0);
    step(1, 0, BP_OPCODE, 8'h80, 8'h10);
    lit_pc("bp_neg", 9);
    step(1, 0, BN_OPCODE, 8'h7F, 8'h10);
    lit_pc("bn_pos", 9);
    step(1, 0, 4'h0, 8'h00, 8'h10);
    lit_pc("nop", 9);

    // CALL/RET through the full stack depth and past both ends.
    do_reset();
    for (int i = 0; i < 10; i++) step(1, 1, 4'h0, 8'h00, 8'h00);
    lit_pc("pc10", 10);
    step(1, 0, CALL_OPCODE, 8'h00, 8'h10); lit_pc("call1", 26);
    step(1, 0, CALL_OPCODE, 8'h00, 8'h10); lit_pc("call2", 42);
    step(1, 0, CALL_OPCODE, 8'h00, 8'h10); lit_pc("call3", 58);
    step(1, 0, CALL_OPCODE, 8'h00, 8'h10); lit_pc("call4", 74);
    check("full4", int'(stack_full), 1);
    step(1, 0, CALL_OPCODE, 8'h00, 8'h10); lit_pc("call5", 74);
    check("ovf_err", int'(stack_err), 1);
    check("ovf_taken", int'(taken), 0);
    step(1, 0, RET_OPCODE, 8'h00, 8'h00); lit_pc("ret1", 59);
    step(1, 0, RET_OPCODE, 8'h00, 8'h00); lit_pc("ret2", 43);
    step(1, 0, RET_OPCODE, 8'h00, 8'h00); lit_pc("ret3", 27);
    step(1, 0, RET_OPCODE, 8'h00, 8'h00); lit_pc("ret4", 11);
    check("empty4", int'(stack_empty), 1);
    step(1, 0, RET_OPCODE, 8'h00, 8'h00); lit_pc("ret5", 11);
    check("unf_err", int'(stack_err), 1);

    // Disabled updates.
    step(0, 1, 4'h0, 8'h00, 8'h00); lit_pc("repc0_inc", 11);
    step(0, 0, CALL_OPCODE, 8'h00, 8'h10); lit_pc("repc0_call", 11);
    check("repc0_empty", int'(stack_empty), 1);
    step(1, 0, CALL_OPCODE, 8'h00, 8'h10); lit_pc("call_pre_rst", 27);
    check("pre_rst_empty", int'(stack_empty), 0);

    // Asynchronous reset between edges while a CALL is set up.
    @(negedge clk);
    REPC = 1; INC = 0; ir_opcode = CALL_OPCODE; ir_operand_addr = 8'h10;
    #2;
    reset_pc = 1;
    #1;
    check("arst_pc", int'(pc), 0);
    check("arst_empty", int'(stack_empty), 1);
    check("arst_err", int'(stack_err), 0);
    check("arst_taken", int'(taken), 0);
    REPC = 0;
    #1;
    reset_pc = 0;
    @(posedge clk);
    #1;
    lit_pc("post_arst", 0);

    step(0, 0, 4'h0, 8'h00, 8'h00);
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
